uart_rx_packet_ctrl: RTL and testbench

Receive-side sequencer that sits behind the UART receiver. It consumes each received byte, indicated by the receiver's data-received flag, and frames the byte stream into packets with the format SOF, LEN, LEN payload bytes, CHK. It buffers the payload, validates the length and the XOR checksum, and only then releases the payload to a downstream consumer over a valid/ready stream. Malformed, timed-out or overrun packets are discarded and reported with single-cycle status pulses.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_pkt_buf.sv | 27 ++
 rtl/uart_rx_packet_ctrl.sv | 157 +++++++++++++++
 tb/tb_uart_rx_packet_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART packet definitions: state encoding and character defaults,
// reused by the receive sequencer and a future transmit-side packetizer.
package uart_pkg;

    localparam int         DATA_WIDTH       = 8;
    localparam logic [7:0] SOF_CHAR_DEFAULT = 8'hA5;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LEN     = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_CHECK   = 3'd3;
    localparam logic [2:0] ST_DRAIN   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_LEN     = ST_LEN,
        S_PAYLOAD = ST_PAYLOAD,
        S_CHECK   = ST_CHECK,
        S_DRAIN   = ST_DRAIN
    } state_t;

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload buffer: simple dual-port register file, synchronous write from the
// framer and asynchronous read for the drain side.
module uart_pkt_buf #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are not reset; every slot is written before it is drained.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_packet_ctrl.sv
// Receive-side packet sequencer: frames SOF/LEN/payload/CHK, validates the
// length and XOR checksum, then drains the buffered payload over valid/ready.
module uart_rx_packet_ctrl
    import uart_pkg::*;
#(
    parameter int                    data_width     = DATA_WIDTH,
    parameter logic [data_width-1:0] SOF_CHAR       = SOF_CHAR_DEFAULT,
    parameter int                    MAX_LEN        = 16,
    parameter int                    TIMEOUT_CYCLES = 20000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [data_width-1:0] rx_data,
    input  logic                  rx_data_recd,
    output logic [data_width-1:0] pkt_data,
    output logic                  pkt_valid,
    input  logic                  pkt_ready,
    output logic                  pkt_last,
    output logic [7:0]            pkt_len,
    output logic                  pkt_err,
    output logic                  rx_overrun,
    output logic                  busy
);

    localparam int              AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int              TW       = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      MAX_LEN8 = 8'(MAX_LEN);

    state_t                  state;
    logic                    rd_d;
    logic                    byte_evt;
    logic                    in_frame;
    logic                    timeout;
    logic [TW-1:0]           tmo_cnt;
    logic [7:0]              len_q;
    logic [7:0]              idx;
    logic [7:0]              rd_idx;
    logic [7:0]              byte_len;
    logic [data_width-1:0]   chk;
    logic [data_width-1:0]   rd_byte;
    logic                    buf_we;

    assign byte_evt = rx_data_recd & ~rd_d;
    assign byte_len = rx_data[7:0];
    assign in_frame = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHECK);
    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign timeout  = in_frame && !byte_evt && (tmo_cnt == TMO_LAST);
    assign buf_we   = (state == S_PAYLOAD) && byte_evt;

    uart_pkt_buf #(
        .DEPTH (MAX_LEN),
        .WIDTH (data_width),
        .AW    (AW)
    ) u_buf (
        .clock (clock),
        .we    (buf_we),
        .waddr (idx[AW-1:0]),
        .wdata (rx_data),
        .raddr (rd_idx[AW-1:0]),
        .rdata (rd_byte)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            rd_d       <= 1'b0;
            tmo_cnt    <= '0;
            len_q      <= '0;
            idx        <= '0;
            rd_idx     <= '0;
            chk        <= '0;
            pkt_valid  <= 1'b0;
            pkt_err    <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rd_d       <= rx_data_recd;
            pkt_err    <= 1'b0;
            rx_overrun <= 1'b0;

            if (byte_evt) begin
                tmo_cnt <= '0;
            end else if (in_frame) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (timeout) begin
                pkt_err <= 1'b1;
                state   <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (byte_evt && rx_data == SOF_CHAR) begin
                            state <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (byte_evt) begin
                            if (byte_len == 8'd0 || byte_len > MAX_LEN8) begin
                                pkt_err <= 1'b1;
                                state   <= S_IDLE;
                            end else begin
                                len_q <= byte_len;
                                chk   <= rx_data;
                                idx   <= '0;
                                state <= S_PAYLOAD;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (byte_evt) begin
                            chk <= chk ^ rx_data;
                            if (idx == len_q - 8'd1) begin
                                state <= S_CHECK;
                            end else begin
                                idx <= idx + 8'd1;
                            end
                        end
                    end
                    S_CHECK: begin
                        if (byte_evt) begin
                            if (rx_data == chk) begin
                                rd_idx    <= '0;
                                pkt_valid <= 1'b1;
                                state     <= S_DRAIN;
                            end else begin
                                pkt_err <= 1'b1;
                                state   <= S_IDLE;
                            end
                        end
                    end
                    S_DRAIN: begin
                        // Bytes arriving while draining are dropped, never framed.
                        if (byte_evt) begin
                            rx_overrun <= 1'b1;
                        end
                        if (pkt_ready) begin
                            if (rd_idx == len_q - 8'd1) begin
                                pkt_valid <= 1'b0;
                                state     <= S_IDLE;
                            end else begin
                                rd_idx <= rd_idx + 8'd1;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign pkt_data = pkt_valid ? rd_byte : '0;
    assign pkt_last = pkt_valid && (rd_idx == len_q - 8'd1);
    assign pkt_len  = len_q;
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Self-checking bench: table vectors, hand-written corner sequences and
// randomized packets checked against a packet-level reference model.
module tb_uart_rx_packet_ctrl;

    localparam int TMO  = 400;
    localparam int MAXL = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_data_recd;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       pkt_ready;
    logic       pkt_last;
    logic [7:0] pkt_len;
    logic       pkt_err;
    logic       rx_overrun;
    logic       busy;

    uart_rx_packet_ctrl #(
        .data_width     (8),
        .SOF_CHAR       (8'hA5),
        .MAX_LEN        (MAXL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_data_recd (rx_data_recd),
        .pkt_data     (pkt_data),
        .pkt_valid    (pkt_valid),
        .pkt_ready    (pkt_ready),
        .pkt_last     (pkt_last),
        .pkt_len      (pkt_len),
        .pkt_err      (pkt_err),
        .rx_overrun   (rx_overrun),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [7:0] len;
    } beat_t;

    typedef struct packed {
        logic [3:0]  n;
        logic [63:0] bytes;
        logic [1:0]  expErr;
        logic [3:0]  expBeats;
        logic [31:0] expData;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         errPulses = 0;
    int         ovrPulses = 0;
    int         bothPulses = 0;
    int         stabViol = 0;
    int         errBase = 0;
    int         ovrBase = 0;
    int         cyc = 0;
    bit         randReady = 1'b0;
    bit         holdPrev = 1'b0;
    beat_t      prevBeat;
    beat_t      beats[$];
    logic [7:0] expPay[$];
    vec_t       vecs[6];

    always @(posedge clock) cyc++;

    always begin
        @(posedge clock);
        #1;
        if (randReady) pkt_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clock) begin
        if (reset) begin
            holdPrev = 1'b0;
        end else begin
            if (pkt_err) errPulses++;
            if (rx_overrun) ovrPulses++;
            if (pkt_err && rx_overrun) bothPulses++;
            if (holdPrev && (!pkt_valid || pkt_data !== prevBeat.data ||
                             pkt_last !== prevBeat.last || pkt_len !== prevBeat.len))
                stabViol++;
            holdPrev = pkt_valid && !pkt_ready;
            prevBeat = '{data: pkt_data, last: pkt_last, len: pkt_len};
            if (pkt_valid && pkt_ready)
                beats.push_back('{data: pkt_data, last: pkt_last, len: pkt_len});
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(posedge clock);
        #1;
        rx_data      = b;
        rx_data_recd = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        rx_data_recd = 1'b0;
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic waitIdle(input string name, input int budget);
        int k = 0;
        while ((busy || pkt_valid) && k < budget) begin
            @(posedge clock);
            #1;
            k++;
        end
        checkOutput(name, {30'd0, busy, pkt_valid}, 32'd0);
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic startPacket();
        beats.delete();
        expPay.delete();
        errBase = errPulses;
        ovrBase = ovrPulses;
    endtask

    // Compares everything observed since startPacket with the expected outcome.
    task automatic verifyPacket(input string name, input int expErr);
        int nb;
        checkOutput({name, "_err"}, errPulses - errBase, expErr);
        checkOutput({name, "_beats"}, beats.size(), expPay.size());
        nb = (beats.size() < expPay.size()) ? beats.size() : expPay.size();
        for (int i = 0; i < nb; i++) begin
            checkOutput($sformatf("%s_data%0d", name, i), beats[i].data, expPay[i]);
            checkOutput($sformatf("%s_last%0d", name, i), beats[i].last,
                        (i == expPay.size() - 1) ? 1 : 0);
            checkOutput($sformatf("%s_len%0d", name, i), beats[i].len, expPay.size());
        end
        beats.delete();
        errBase = errPulses;
    endtask

    function automatic logic [7:0] xorSum(input logic [7:0] len);
        logic [7:0] s = len;
        foreach (expPay[i]) s = s ^ expPay[i];
        return s;
    endfunction

    initial begin
        vec_t       v;
        logic [7:0] len;
        logic [7:0] chk;
        logic [7:0] b;
        int         t0;
        bit         bad;

        vecs[0] = '{n: 4'd6, bytes: 64'hA503112233030000, expErr: 2'd0, expBeats: 4'd3, expData: 32'h11223300};
        vecs[1] = '{n: 4'd5, bytes: 64'hA502AA5500000000, expErr: 2'd1, expBeats: 4'd0, expData: 32'h0};
        vecs[2] = '{n: 4'd4, bytes: 64'hA5015A5B00000000, expErr: 2'd0, expBeats: 4'd1, expData: 32'h5A000000};
        vecs[3] = '{n: 4'd2, bytes: 64'hA500000000000000, expErr: 2'd1, expBeats: 4'd0, expData: 32'h0};
        vecs[4] = '{n: 4'd2, bytes: 64'hA511000000000000, expErr: 2'd1, expBeats: 4'd0, expData: 32'h0};
        vecs[5] = '{n: 4'd2, bytes: 64'h00FF000000000000, expErr: 2'd0, expBeats: 4'd0, expData: 32'h0};

        reset        = 1'b1;
        rx_data      = 8'h00;
        rx_data_recd = 1'b0;
        pkt_ready    = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_outputs",
                    {pkt_data, pkt_len, 4'd0, pkt_valid, pkt_last, pkt_err, rx_overrun, busy}, 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        for (int k = 0; k < 6; k++) begin
            v = vecs[k];
            startPacket();
            for (int i = 0; i < int'(v.expBeats); i++) expPay.push_back(v.expData[31 - 8*i -: 8]);
            for (int i = 0; i < int'(v.n); i++) applyStimulus(v.bytes[63 - 8*i -: 8]);
            waitIdle($sformatf("vec%0d_idle", k), 500);
            verifyPacket($sformatf("vec%0d", k), int'(v.expErr));
        end

        startPacket();
        randReady = 1'b1;
        for (int i = 0; i < MAXL; i++) expPay.push_back(8'(i * 17 + 3));
        chk = xorSum(8'(MAXL));
        applyStimulus(8'hA5);
        applyStimulus(8'(MAXL));
        foreach (expPay[i]) applyStimulus(expPay[i]);
        applyStimulus(chk);
        waitIdle("maxlen_idle", 1000);
        verifyPacket("maxlen", 0);
        randReady = 1'b0;
        #20;

        startPacket();
        pkt_ready = 1'b0;
        expPay.push_back(8'hC3);
        expPay.push_back(8'h3C);
        applyStimulus(8'hA5);
        applyStimulus(8'h02);
        applyStimulus(8'hC3);
        applyStimulus(8'h3C);
        applyStimulus(8'hFD);
        t0 = cyc;
        applyStimulus(8'hA5);
        while (cyc - t0 < 100) begin
            @(posedge clock);
            #1;
        end
        checkOutput("bp_valid", pkt_valid, 1);
        checkOutput("bp_data", pkt_data, 8'hC3);
        checkOutput("bp_last", pkt_last, 0);
        checkOutput("bp_len", pkt_len, 2);
        checkOutput("bp_overrun", ovrPulses - ovrBase, 1);
        checkOutput("bp_no_beat", beats.size(), 0);
        pkt_ready = 1'b1;
        waitIdle("bp_idle", 100);
        verifyPacket("bp", 0);
        checkOutput("bp_dropped_not_sof", busy, 0);

        startPacket();
        applyStimulus(8'hA5);
        applyStimulus(8'h04);
        applyStimulus(8'h01);
        repeat (TMO + 50) @(posedge clock);
        #1;
        checkOutput("tmo_busy", busy, 0);
        verifyPacket("tmo", 1);

        startPacket();
        applyStimulus(8'hA5);
        applyStimulus(8'h04);
        applyStimulus(8'h01);
        checkOutput("pre_reset_busy", busy, 1);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_outputs",
                    {pkt_data, pkt_len, 4'd0, pkt_valid, pkt_last, pkt_err, rx_overrun, busy}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        randReady = 1'b1;
        for (int p = 0; p < 20; p++) begin
            startPacket();
            len = 8'($urandom_range(0, MAXL + 2));
            applyStimulus(8'hA5);
            applyStimulus(len);
            if (len == 0 || len > MAXL) begin
                bad = 1'b1;
            end else begin
                for (int i = 0; i < int'(len); i++) begin
                    b = 8'($urandom_range(0, 255));
                    expPay.push_back(b);
                    applyStimulus(b);
                end
                chk = xorSum(len);
                bad = ($urandom_range(0, 3) == 0);
                if (bad) chk = chk ^ 8'(1 << $urandom_range(0, 7));
                applyStimulus(chk);
            end
            if (bad) expPay.delete();
            waitIdle($sformatf("rand%0d_idle", p), 2000);
            verifyPacket($sformatf("rand%0d", p), bad ? 1 : 0);
        end
        randReady = 1'b0;

        checkOutput("err_overrun_exclusive", bothPulses, 0);
        checkOutput("hold_stability", stabViol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
